// File: rtl/opc7_bus_arbiter_pkg.sv
// Shared opc7 definitions: bus widths, owner codes and arbiter FSM states.
package opc7_bus_arbiter_pkg;

    localparam int AW_DEF = 20;
    localparam int DW_DEF = 32;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_CPU  = 2'd1;
    localparam logic [1:0] OWN_DMA  = 2'd2;

    typedef enum logic [1:0] {
        ARB      = 2'd0,
        HOLD_CPU = 2'd1,
        HOLD_DMA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/opc7_bus_arbiter_starve_cnt.sv
// Saturating count of cycles the DMA requester has waited without owning the bus.
module opc7_starve_cnt #(
    parameter int MAX_WAIT = 4
) (
    input  logic clk,
    input  logic reset_b,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [7:0] MAX = 8'(MAX_WAIT);

    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            wait_cnt <= 8'd0;
        end else if (clr) begin
            wait_cnt <= 8'd0;
        end else if (inc && wait_cnt != MAX) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

    assign at_max = (wait_cnt == MAX);

endmodule

// File: rtl/opc7_bus_arbiter.sv
// Shares the opc7 memory bus between the CPU and a DMA requester;
// CPU I/O cycles bypass arbitration and go straight to the I/O port.
module opc7_bus_arbiter
    import opc7_bus_arbiter_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = 4
) (
    input  logic          clk,
    input  logic          reset_b,
    input  logic [AW-1:0] cpu_address,
    input  logic [DW-1:0] cpu_dout,
    input  logic          cpu_rnw,
    input  logic          cpu_vpa,
    input  logic          cpu_vda,
    input  logic          cpu_vio,
    output logic [DW-1:0] cpu_din,
    output logic          cpu_clken,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [DW-1:0] dma_wdata,
    output logic          dma_ack,
    output logic [DW-1:0] dma_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          io_en,
    output logic          io_we,
    output logic [AW-1:0] io_addr,
    output logic [DW-1:0] io_wdata,
    input  logic [DW-1:0] io_rdata,
    input  logic          io_ready
);

    arb_state_t state;
    arb_state_t state_nx;
    logic [1:0] owner;
    logic       cpu_mem;
    logic       cpu_io;
    logic       at_max;
    logic       grant;

    assign cpu_mem = cpu_vpa | cpu_vda;
    assign cpu_io  = cpu_vio;

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state <= ARB;
        end else begin
            state <= state_nx;
        end
    end

    // In ARB a starving DMA, or an idle CPU, lets the DMA take the bus.
    always_comb begin
        owner    = OWN_NONE;
        state_nx = state;
        unique case (state)
            ARB: begin
                if (dma_req && (at_max || !cpu_mem)) begin
                    owner = OWN_DMA;
                end else if (cpu_mem) begin
                    owner = OWN_CPU;
                end else if (dma_req) begin
                    owner = OWN_DMA;
                end
                if (!mem_ready) begin
                    if (owner == OWN_CPU) begin
                        state_nx = HOLD_CPU;
                    end else if (owner == OWN_DMA) begin
                        state_nx = HOLD_DMA;
                    end
                end
            end
            HOLD_CPU: begin
                owner = OWN_CPU;
                if (mem_ready) begin
                    state_nx = ARB;
                end
            end
            HOLD_DMA: begin
                owner = OWN_DMA;
                if (mem_ready) begin
                    state_nx = ARB;
                end
            end
            default: begin
                state_nx = ARB;
            end
        endcase
    end

    assign grant = reset_b && (owner != OWN_NONE);

    assign mem_en    = grant;
    assign mem_we    = grant && ((owner == OWN_DMA) ? dma_we : !cpu_rnw);
    assign mem_addr  = (owner == OWN_DMA) ? dma_addr : cpu_address;
    assign mem_wdata = (owner == OWN_DMA) ? dma_wdata : cpu_dout;

    assign dma_ack   = grant && (owner == OWN_DMA) && mem_ready;
    assign dma_rdata = mem_rdata;

    // Held high in reset so the CPU's reset synchroniser keeps stepping.
    assign cpu_clken = !reset_b
                     || ((owner == OWN_CPU) && mem_ready)
                     || (cpu_io && io_ready)
                     || (!cpu_mem && !cpu_io);
    assign cpu_din   = cpu_io ? io_rdata : mem_rdata;

    assign io_en    = reset_b && cpu_io;
    assign io_we    = reset_b && cpu_io && !cpu_rnw;
    assign io_addr  = cpu_address;
    assign io_wdata = cpu_dout;

    opc7_starve_cnt #(
        .MAX_WAIT(MAX_WAIT)
    ) u_starve (
        .clk    (clk),
        .reset_b(reset_b),
        .inc    (dma_req && (owner != OWN_DMA)),
        .clr    (dma_ack || !dma_req),
        .at_max (at_max)
    );

endmodule

// File: tb/tb_opc7_bus_arbiter.sv
// Directed and randomized checks of opc7_bus_arbiter against a cycle model.
module tb_opc7_bus_arbiter;

    localparam int AW       = 20;
    localparam int DW       = 32;
    localparam int MAX_WAIT = 4;

    logic          clk;
    logic          reset_b;
    logic [AW-1:0] cpu_address;
    logic [DW-1:0] cpu_dout;
    logic          cpu_rnw;
    logic          cpu_vpa;
    logic          cpu_vda;
    logic          cpu_vio;
    logic [DW-1:0] cpu_din;
    logic          cpu_clken;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [DW-1:0] dma_wdata;
    logic          dma_ack;
    logic [DW-1:0] dma_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          io_en;
    logic          io_we;
    logic [AW-1:0] io_addr;
    logic [DW-1:0] io_wdata;
    logic [DW-1:0] io_rdata;
    logic          io_ready;

    int checks = 0;
    int errors = 0;

    int m_lock = 0;
    int m_wcnt = 0;
    bit last_clken = 1'b1;
    bit last_ack = 1'b0;

    opc7_bus_arbiter #(
        .AW(AW),
        .DW(DW),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk        (clk),
        .reset_b    (reset_b),
        .cpu_address(cpu_address),
        .cpu_dout   (cpu_dout),
        .cpu_rnw    (cpu_rnw),
        .cpu_vpa    (cpu_vpa),
        .cpu_vda    (cpu_vda),
        .cpu_vio    (cpu_vio),
        .cpu_din    (cpu_din),
        .cpu_clken  (cpu_clken),
        .dma_req    (dma_req),
        .dma_we     (dma_we),
        .dma_addr   (dma_addr),
        .dma_wdata  (dma_wdata),
        .dma_ack    (dma_ack),
        .dma_rdata  (dma_rdata),
        .mem_en     (mem_en),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .io_en      (io_en),
        .io_we      (io_we),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_ready   (io_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h",
                     name, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Cycle model: owner is the locked one, else chosen by the grant rules.
    always @(negedge clk) begin : model
        int own;
        bit cm;
        bit ack;
        bit ck;
        if (!reset_b) begin
            chk("rst_mem_en", mem_en, 0);
            chk("rst_mem_we", mem_we, 0);
            chk("rst_io_en", io_en, 0);
            chk("rst_io_we", io_we, 0);
            chk("rst_dma_ack", dma_ack, 0);
            chk("rst_clken", cpu_clken, 1);
            m_lock = 0;
            m_wcnt = 0;
            last_clken = 1'b1;
            last_ack = 1'b0;
        end else begin
            cm = cpu_vpa | cpu_vda;
            own = m_lock;
            if (own == 0) begin
                if (dma_req && (m_wcnt == MAX_WAIT || !cm)) own = 2;
                else if (cm) own = 1;
                else if (dma_req) own = 2;
            end
            ack = (own == 2) && mem_ready;
            ck = ((own == 1) && mem_ready) || (cpu_vio && io_ready)
               || (!cm && !cpu_vio);
            chk("mem_en", mem_en, own != 0);
            if (own != 0) begin
                chk("mem_we", mem_we, (own == 1) ? !cpu_rnw : dma_we);
                chk("mem_addr", mem_addr, (own == 1) ? cpu_address : dma_addr);
                chk("mem_wdata", mem_wdata, (own == 1) ? cpu_dout : dma_wdata);
            end
            chk("cpu_clken", cpu_clken, ck);
            chk("dma_ack", dma_ack, ack);
            if (ack) chk("dma_rdata", dma_rdata, mem_rdata);
            chk("cpu_din", cpu_din, cpu_vio ? io_rdata : mem_rdata);
            chk("io_en", io_en, cpu_vio);
            chk("io_we", io_we, cpu_vio && !cpu_rnw);
            chk("io_addr", io_addr, cpu_address);
            chk("io_wdata", io_wdata, cpu_dout);
            m_lock = (own != 0 && !mem_ready) ? own : 0;
            if (ack || !dma_req) m_wcnt = 0;
            else if (own != 2 && m_wcnt < MAX_WAIT) m_wcnt++;
            last_clken = ck;
            last_ack = ack;
        end
    end

    initial begin : stim
        int n;
        int op;
        int rst_left;
        reset_b = 1'b0;
        cpu_address = '0;
        cpu_dout = '0;
        cpu_rnw = 1'b1;
        cpu_vpa = 1'b1;
        cpu_vda = 1'b0;
        cpu_vio = 1'b0;
        dma_req = 1'b0;
        dma_we = 1'b0;
        dma_addr = '0;
        dma_wdata = '0;
        mem_rdata = '0;
        mem_ready = 1'b1;
        io_rdata = '0;
        io_ready = 1'b0;
        @(negedge clk);
        chk("t0_rst_clken", cpu_clken, 1);
        chk("t0_rst_mem_en", mem_en, 0);
        repeat (2) tick();
        reset_b = 1'b1;

        // Zero-wait fetches, no DMA
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            cpu_vpa = 1'b1;
            cpu_address = AW'(i);
            mem_ready = 1'b1;
            @(negedge clk);
            if (mem_en && cpu_clken) n++;
            chk("t1_addr", mem_addr, i);
            chk("t1_ack", dma_ack, 0);
        end
        chk("t1_count", n, 10);

        // DMA write wins after MAX_WAIT cycles of CPU traffic
        for (int k = 1; k <= 6; k++) begin
            tick();
            cpu_vpa = 1'b0;
            cpu_vda = 1'b1;
            cpu_rnw = 1'b1;
            if (last_clken) cpu_address = AW'(32'h1000 + k);
            dma_req = (k <= 5);
            dma_we = 1'b1;
            dma_addr = 20'h00100;
            dma_wdata = 32'hDEADBEEF;
            @(negedge clk);
            if (k < 5) begin
                chk("t2_ack_early", dma_ack, 0);
                chk("t2_clken_early", cpu_clken, 1);
            end else if (k == 5) begin
                chk("t2_ack", dma_ack, 1);
                chk("t2_addr", mem_addr, 20'h00100);
                chk("t2_wdata", mem_wdata, 32'hDEADBEEF);
                chk("t2_we", mem_we, 1);
                chk("t2_clken", cpu_clken, 0);
            end else begin
                chk("t2_cpu_back", cpu_clken, 1);
                chk("t2_cpu_we", mem_we, 0);
            end
        end

        // Slow CPU read; DMA arriving mid-hold waits
        for (int c = 1; c <= 5; c++) begin
            tick();
            cpu_vda = (c <= 4);
            cpu_rnw = 1'b1;
            cpu_address = 20'h00040;
            mem_ready = (c >= 4);
            mem_rdata = (c == 4) ? 32'h12345678 : $urandom;
            dma_req = (c >= 2);
            dma_we = 1'b0;
            dma_addr = 20'h00500;
            @(negedge clk);
            if (c <= 4) begin
                chk("t3_clken", cpu_clken, c == 4);
                chk("t3_addr", mem_addr, 20'h00040);
                chk("t3_ack", dma_ack, 0);
                if (c == 4) chk("t3_din", cpu_din, 32'h12345678);
            end else begin
                chk("t3_dma_ack", dma_ack, 1);
                chk("t3_dma_addr", mem_addr, 20'h00500);
            end
        end

        // CPU I/O read overlapped with a DMA memory read
        for (int c = 1; c <= 3; c++) begin
            tick();
            cpu_vda = 1'b0;
            cpu_vio = 1'b1;
            cpu_rnw = 1'b1;
            cpu_address = 20'h00010;
            io_ready = (c == 3);
            io_rdata = (c == 3) ? 32'h000000A5 : $urandom;
            dma_req = (c == 1);
            dma_we = 1'b0;
            dma_addr = 20'h00200;
            mem_ready = 1'b1;
            mem_rdata = 32'hCAFE0001;
            @(negedge clk);
            chk("t4_io_en", io_en, 1);
            chk("t4_io_addr", io_addr, 20'h00010);
            chk("t4_clken", cpu_clken, c == 3);
            chk("t4_ack", dma_ack, c == 1);
            if (c == 1) chk("t4_rdata", dma_rdata, 32'hCAFE0001);
            if (c == 3) chk("t4_din", cpu_din, 32'h000000A5);
        end

        // Reset while the DMA holds the bus
        tick();
        cpu_vio = 1'b0;
        io_ready = 1'b0;
        dma_req = 1'b1;
        dma_we = 1'b1;
        dma_addr = 20'h00300;
        dma_wdata = 32'h000055AA;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("t5_grant", mem_en, 1);
        chk("t5_ack0", dma_ack, 0);
        tick();
        cpu_vda = 1'b1;
        cpu_address = 20'h00044;
        @(negedge clk);
        chk("t5_hold_clken", cpu_clken, 0);
        chk("t5_hold_addr", mem_addr, 20'h00300);
        tick();
        reset_b = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk("t5_rst_mem_en", mem_en, 0);
        chk("t5_rst_clken", cpu_clken, 1);
        chk("t5_rst_ack", dma_ack, 0);
        tick();
        reset_b = 1'b1;
        cpu_vda = 1'b0;
        @(negedge clk);
        chk("t5_retry_ack", dma_ack, 1);
        chk("t5_retry_addr", mem_addr, 20'h00300);

        // Idle CPU cycle lets DMA through without stall
        tick();
        dma_req = 1'b1;
        dma_we = 1'b0;
        dma_addr = 20'h00600;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t6_clken", cpu_clken, 1);
        chk("t6_ack", dma_ack, 1);
        chk("t6_mem_en", mem_en, 1);
        tick();
        dma_req = 1'b0;

        // Randomized traffic
        rst_left = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            if (rst_left > 0) begin
                rst_left--;
                if (rst_left == 0) reset_b = 1'b1;
            end else if ($urandom % 250 == 0) begin
                reset_b = 1'b0;
                rst_left = 2;
            end
            if (last_clken) begin
                op = $urandom % 6;
                cpu_vpa = (op == 1);
                cpu_vda = (op == 2 || op == 3);
                cpu_vio = (op >= 4);
                cpu_rnw = !(op == 3 || op == 5);
                cpu_address = AW'($urandom);
                cpu_dout = $urandom;
            end
            if (!dma_req || last_ack) begin
                dma_req = ($urandom % 3 == 0);
                dma_we = $urandom % 2;
                dma_addr = AW'($urandom);
                dma_wdata = $urandom;
            end
            mem_ready = ($urandom % 10 < 6);
            io_ready = ($urandom % 3 == 0);
            mem_rdata = $urandom;
            io_rdata = $urandom;
        end
        reset_b = 1'b1;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
